// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 datapath: one initial addRoundKey, then NR rounds,
// each waiting SBOX_LAT cycles for the synchronous S-box before committing state and key.
module aes_round_ctrl #(
    parameter int NR       = 10,
    parameter int SBOX_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ld_init,
    output logic       st_en,
    output logic       key_en,
    output logic       skip_mix,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    // Handshake: start is a level request sampled only in IDLE and DONE; done holds while
    // start stays high, and the host must drop start before the next request is accepted.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_SUB  = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_LOAD  = 3'(SBOX_LAT - 1);
    localparam logic [3:0] ROUND_LAST = 4'(NR);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [2:0] wcnt_q,  wcnt_d;

    // AES RC[r]: start at 01 and xtime-double r-1 times, reducing by 1B on MSB carry.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 2; i < 16; i++) begin
            if (4'(i) <= r) begin
                c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
            end
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_SUB;
                round_d = 4'd1;
                wcnt_d  = WAIT_LOAD;
            end
            S_SUB: begin
                if (wcnt_q == 3'd0) begin
                    state_d = S_UPD;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            S_UPD: begin
                // round saturates at NR and is only cleared on the way back to IDLE.
                if (round_q == ROUND_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                    round_d = round_q + 4'd1;
                    wcnt_d  = WAIT_LOAD;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
                wcnt_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        ld_init  = 1'b0;
        st_en    = 1'b0;
        key_en   = 1'b0;
        skip_mix = 1'b0;
        rcon     = 8'h00;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_INIT: begin
                ld_init = 1'b1;
                busy    = 1'b1;
            end
            S_SUB: begin
                busy = 1'b1;
                rcon = rcon_of(round_q);
            end
            S_UPD: begin
                st_en    = 1'b1;
                key_en   = 1'b1;
                skip_mix = (round_q == ROUND_LAST);
                busy     = 1'b1;
                rcon     = rcon_of(round_q);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign round     = round_q;
    assign dbg_state = state_q;

endmodule
